// File: rtl/intra_pkg.sv
// Shared types and constants for the 16x16 luma intra path.
//   mode_t  : intra prediction mode encoding (V, H, DC)
//   state_t : mode-decision FSM states
package intra_pkg;

    localparam int unsigned MB_DIM   = 16;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned SAD_W    = 16;
    localparam int unsigned ROWSAD_W = 12;
    localparam int unsigned RES_W    = 9;

    typedef enum logic [1:0] {
        MODE_V  = 2'd0,
        MODE_H  = 2'd1,
        MODE_DC = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StSad,
        StDecide,
        StResid
    } state_t;

endpackage

// File: rtl/sad_row16.sv
// Combinational sum of absolute differences over one 16-pixel row.
// Ports:
//   orig_px : 16 original pixels
//   pred_px : 16 predicted pixels
//   sad     : sum |orig - pred|, at most 16 * 255 = 4080
module sad_row16
    import intra_pkg::*;
(
    input  logic [MB_DIM-1:0][PIX_W-1:0] orig_px,
    input  logic [MB_DIM-1:0][PIX_W-1:0] pred_px,
    output logic [ROWSAD_W-1:0]          sad
);

    always_comb begin
        sad = '0;
        for (int i = 0; i < int'(MB_DIM); i++) begin
            if (orig_px[i] > pred_px[i]) begin
                sad = sad + ROWSAD_W'(orig_px[i] - pred_px[i]);
            end else begin
                sad = sad + ROWSAD_W'(pred_px[i] - orig_px[i]);
            end
        end
    end

endmodule

// File: rtl/mode_decision_luma16x16.sv
// 16x16 luma intra mode decision: accumulates V/H/DC SAD one row per cycle,
// picks the cheapest mode (ties go to the lower mode number) and streams the
// signed residual rows over a valid/ready handshake.
// Ports:
//   clk, reset (async, active-low), start (accepted in idle only)
//   orig, vpred, hpred, dcpred : raster-order pixel arrays, held stable by upstream
//   busy, best_mode, best_sad  : status and decision
//   res_valid/res_ready, res_row_idx, res_row : residual row stream
//   done : one-cycle pulse after the last row handshake
module mode_decision_luma16x16 #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned MB_DIM = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [MB_DIM*MB_DIM-1:0][PIX_W-1:0] orig,
    input  logic [MB_DIM*MB_DIM-1:0][PIX_W-1:0] vpred,
    input  logic [MB_DIM*MB_DIM-1:0][PIX_W-1:0] hpred,
    input  logic [MB_DIM*MB_DIM-1:0][PIX_W-1:0] dcpred,
    output logic                                busy,
    output logic [1:0]                          best_mode,
    output logic [15:0]                         best_sad,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [3:0]                          res_row_idx,
    output logic [MB_DIM-1:0][PIX_W:0]          res_row,
    output logic                                done
);

    import intra_pkg::*;

    state_t                    state_q, state_d;
    logic [3:0]                row_q, row_d;
    logic [2:0][SAD_W-1:0]     acc_q, acc_d;
    mode_t                     best_mode_q, best_mode_d;
    logic [SAD_W-1:0]          best_sad_q, best_sad_d;
    logic                      done_q, done_d;

    logic [MB_DIM-1:0][PIX_W-1:0] orig_row, v_row, h_row, dc_row, pred_row;
    logic [ROWSAD_W-1:0]          sad_v, sad_h, sad_dc;
    logic                         last_row;

    // The arrays are not latched; the current row is picked straight from the inputs.
    always_comb begin
        for (int c = 0; c < int'(MB_DIM); c++) begin
            orig_row[c] = orig[int'(row_q) * int'(MB_DIM) + c];
            v_row[c]    = vpred[int'(row_q) * int'(MB_DIM) + c];
            h_row[c]    = hpred[int'(row_q) * int'(MB_DIM) + c];
            dc_row[c]   = dcpred[int'(row_q) * int'(MB_DIM) + c];
        end
    end

    sad_row16 u_sad_v  (.orig_px(orig_row), .pred_px(v_row),  .sad(sad_v));
    sad_row16 u_sad_h  (.orig_px(orig_row), .pred_px(h_row),  .sad(sad_h));
    sad_row16 u_sad_dc (.orig_px(orig_row), .pred_px(dc_row), .sad(sad_dc));

    assign last_row = (row_q == 4'd15);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        acc_d       = acc_q;
        best_mode_d = best_mode_q;
        best_sad_d  = best_sad_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSad;
                    row_d   = 4'd0;
                    acc_d   = '0;
                end
            end
            StSad: begin
                acc_d[0] = acc_q[0] + SAD_W'(sad_v);
                acc_d[1] = acc_q[1] + SAD_W'(sad_h);
                acc_d[2] = acc_q[2] + SAD_W'(sad_dc);
                row_d    = row_q + 4'd1;
                if (last_row) begin
                    state_d = StDecide;
                end
            end
            StDecide: begin
                // <= comparisons give V priority over H over DC on ties.
                if (acc_q[0] <= acc_q[1] && acc_q[0] <= acc_q[2]) begin
                    best_mode_d = MODE_V;
                    best_sad_d  = acc_q[0];
                end else if (acc_q[1] <= acc_q[2]) begin
                    best_mode_d = MODE_H;
                    best_sad_d  = acc_q[1];
                end else begin
                    best_mode_d = MODE_DC;
                    best_sad_d  = acc_q[2];
                end
                row_d   = 4'd0;
                state_d = StResid;
            end
            StResid: begin
                if (res_ready) begin
                    row_d = row_q + 4'd1;
                    if (last_row) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            row_q       <= 4'd0;
            acc_q       <= '0;
            best_mode_q <= MODE_V;
            best_sad_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            best_mode_q <= best_mode_d;
            best_sad_q  <= best_sad_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        unique case (best_mode_q)
            MODE_H:  pred_row = h_row;
            MODE_DC: pred_row = dc_row;
            default: pred_row = v_row;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign res_valid   = (state_q == StResid);
    assign res_row_idx = res_valid ? row_q : 4'd0;
    assign best_mode   = best_mode_q;
    assign best_sad    = best_sad_q;
    assign done        = done_q;

    // Residual is gated so it reads zero outside the streaming phase.
    always_comb begin
        for (int c = 0; c < int'(MB_DIM); c++) begin
            res_row[c] = res_valid ? ({1'b0, orig_row[c]} - {1'b0, pred_row[c]}) : '0;
        end
    end

endmodule

// File: doc/mode_decision_luma16x16.md
# mode_decision_luma16x16

Downstream consumer of the 16x16 luma intra predictor. Takes the original macroblock and the vertical, horizontal and DC prediction arrays. Accumulates a per-mode SAD row by row, selects the cheapest mode, then streams the signed residual rows (original minus chosen prediction) to the transform stage over a valid/ready handshake.

## Interface
Parameters:
- `PIX_W`, 8: pixel bit width.
- `MB_DIM`, 16: macroblock edge; only 16 is supported.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `orig`  in  8 x [255:0]  original pixels, raster order (index = col + 16*row).
- `vpred`, `hpred`, `dcpred`  in  8 x [255:0]  predictions, same indexing.
- `busy`  out  1  high from the cycle after accepted `start` until the cycle after the last residual handshake.
- `best_mode`  out  2  0=V, 1=H, 2=DC; valid from DECIDE onward.
- `best_sad`  out  16  SAD of the chosen mode.
- `res_valid`  out  1  residual row available.
- `res_ready`  in  1  downstream accepts the row.
- `res_row_idx`  out  4  row number of `res_row`.
- `res_row`  out  9 x [15:0]  signed residual, element c = orig − pred at column c.
- `done`  out  1  one-cycle pulse after the final row handshake.

## Operation
- Input contract: upstream holds `orig`/`*pred` stable from `start` until `done`. The block does not latch the arrays; it indexes them by an internal row counter.
- FSM states: IDLE, SAD, DECIDE, RESID.
- IDLE: `start`=1 → SAD, row counter = 0, the three SAD accumulators cleared.
- SAD: one row per cycle. For each mode, sum |orig−pred| over 16 pixels (12-bit row sum, max 4080) and add it to a 16-bit accumulator (max 65280, no overflow). After row 15 → DECIDE.
- DECIDE: one cycle. Picks the minimum SAD. Ties resolve to the lower mode number (V > H > DC priority). Registers `best_mode` and `best_sad`, sets row counter = 0 → RESID.
- RESID: `res_valid`=1; `res_row` and `res_row_idx` are driven from the row counter and `best_mode`.
  - On `res_valid && res_ready`, row counter increments.
  - After the row-15 handshake: `done` pulses, `res_valid` drops, → IDLE.
- Residual: zero-extend both operands to 9 bits, subtract; range −255..+255 in two's complement.
- `start` outside IDLE is ignored; there is no queueing.
- `best_mode`/`best_sad` hold their values until the next DECIDE.

## Timing
- Reset (asynchronous assert) drives all outputs to 0: `busy`, `done`, `res_valid`, `res_row_idx`, `res_row`, `best_mode`, `best_sad`. FSM → IDLE; accumulators and counter are zeroed.
- Reset mid-operation aborts the macroblock; no `done` is issued.
- Cycle numbering, with `start` sampled at cycle 0:
  - SAD rows are processed in cycles 1–16.
  - DECIDE is cycle 17.
  - First `res_valid` is cycle 18.
- With `res_ready` held high, row 15 hands off at cycle 33, `done` pulses at cycle 34, and a new `start` is accepted at cycle 34.
- Handshake rules:
  - While `res_valid`=1 and `res_ready`=0, `res_row` and `res_row_idx` stay stable.
  - `res_valid` never drops before the handshake.
  - `res_ready` may toggle freely.
- Zero-bubble streaming: 16 rows in 16 cycles when `res_ready` is constantly high.

## Structure
- Shared package `intra_pkg`:
  - `mode_t` enum (`MODE_V`=0, `MODE_H`=1, `MODE_DC`=2).
  - Constants `MB_DIM`=16, `PIX_W`=8, `SAD_W`=16, `ROWSAD_W`=12, `RES_W`=9.
  - FSM state typedef.
- One sub-module: `sad_row16`, combinational. Takes 16 orig pixels and 16 pred pixels and outputs a 12-bit SAD. It is instantiated three times, once per mode.
- Residual subtraction and the min/tie-break logic stay in the top module.

## Test plan
1. orig = vpred = ramp (pixel = index mod 256); hpred = all 0; dcpred = all 128 → `best_mode`=0, `best_sad`=0, all 16 rows of residual = 0, `done` at cycle 34.
2. orig all 10; vpred, hpred, dcpred all 9 → all SADs 256, tie resolves to `best_mode`=0 (V), `best_sad`=256, every residual element +1.
3. orig all 255; vpred all 0; hpred all 0; dcpred all 255 → `best_mode`=2, `best_sad`=0. Repeat with dcpred all 0 → `best_mode`=0, `best_sad`=65280, residual +255. Repeat with orig all 0 and preds all 255 → residual −255 (9'h101).
4. `res_ready` low for 3 cycles while row 5 is presented → row 5 data and `res_row_idx`=5 held stable; exactly 16 handshakes in order 0..15; `done` delayed by 3 cycles.
5. `reset` asserted at cycle 9 (mid SAD) → all outputs 0 immediately; no `done`. A fresh `start` then completes with correct results.
6. `start` pulsed at cycles 5 and 20 during an operation → ignored, single `done`. `start` at the `done` cycle → accepted; second macroblock completes back-to-back.
